// File: rtl/dma_port_arbiter.sv
// dma_port_arbiter
// Shares one DMA engine between NREQ requesters. A round-robin arbiter picks
// a requester, latches its descriptor, pulses a start to the engine, and waits
// for the engine's finish pulse. It then returns a done pulse to the owner.
// A watchdog forces completion when the engine never finishes, and sets a
// sticky timeout flag. i_clr aborts the current transfer without a done pulse.
module dma_port_arbiter #(
    parameter int NREQ = 3,
    parameter int TO_W = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic [NREQ-1:0]      i_req,
    input  logic [4*NREQ-1:0]    i_mode,
    input  logic [32*NREQ-1:0]   i_src,
    input  logic [32*NREQ-1:0]   i_dest,
    input  logic [32*NREQ-1:0]   i_lines,
    output logic [NREQ-1:0]      o_grant,
    output logic [NREQ-1:0]      o_done,
    output logic                 o_dma_start,
    output logic [3:0]           o_dma_mode,
    output logic [31:0]          o_src_start,
    output logic [31:0]          o_dest_start,
    output logic [31:0]          o_d_lines,
    input  logic                 i_dma_finish,
    output logic                 o_busy,
    output logic [2:0]           o_owner,
    output logic                 o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [2:0]      LAST_IDX = 3'(NREQ - 1);
    localparam logic [TO_W-1:0] CNT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] CNT_MAX  = {TO_W{1'b1}};

    state_e            state_q;
    logic [2:0]        ptr_q;
    logic [2:0]        ptr_d;
    logic [TO_W-1:0]   cnt_q;
    logic [TO_W-1:0]   cnt_d;
    logic              cnt_max_s;

    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   done_q;
    logic              start_q;
    logic [3:0]        mode_q;
    logic [31:0]       src_q;
    logic [31:0]       dest_q;
    logic [31:0]       lines_q;
    logic [2:0]        owner_q;
    logic              timeout_q;

    logic              found_s;
    logic [2:0]        sel_s;
    logic [NREQ-1:0]   sel_oh_s;
    logic [NREQ-1:0]   owner_oh_s;
    logic [3:0]        mode_sel_s;
    logic [31:0]       src_sel_s;
    logic [31:0]       dest_sel_s;
    logic [31:0]       lines_sel_s;

    // Round-robin pick. The first pass covers indices at or above the pointer. The second pass wraps to the lowest set bit.
    always_comb begin
        found_s = 1'b0;
        sel_s   = 3'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found_s && i_req[j] && (j >= int'(ptr_q))) begin
                found_s = 1'b1;
                sel_s   = 3'(j);
            end else begin
                found_s = found_s;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found_s && i_req[j]) begin
                found_s = 1'b1;
                sel_s   = 3'(j);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Select the winning requester's descriptor fields from the packed buses.
    always_comb begin
        mode_sel_s  = 4'd0;
        src_sel_s   = 32'd0;
        dest_sel_s  = 32'd0;
        lines_sel_s = 32'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (3'(j) == sel_s) begin
                mode_sel_s  = i_mode[4*j +: 4];
                src_sel_s   = i_src[32*j +: 32];
                dest_sel_s  = i_dest[32*j +: 32];
                lines_sel_s = i_lines[32*j +: 32];
            end else begin
                mode_sel_s = mode_sel_s;
            end
        end
    end

    assign sel_oh_s   = ONE_HOT0 << sel_s;
    assign owner_oh_s = ONE_HOT0 << owner_q;
    assign ptr_d      = (sel_s == LAST_IDX) ? 3'd0 : (sel_s + 3'd1);
    assign cnt_d      = cnt_q + CNT_ONE;
    assign cnt_max_s  = (cnt_d == CNT_MAX);

    // Control FSM with registered pulses, descriptor latch, pointer and watchdog.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 3'd0;
            cnt_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            start_q   <= 1'b0;
            mode_q    <= 4'd0;
            src_q     <= 32'd0;
            dest_q    <= 32'd0;
            lines_q   <= 32'd0;
            owner_q   <= 3'd0;
            timeout_q <= 1'b0;
        end else if (i_clr) begin
            // Abort: the pointer, the owner and the descriptor are deliberately kept.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found_s) begin
                        mode_q  <= mode_sel_s;
                        src_q   <= src_sel_s;
                        dest_q  <= dest_sel_s;
                        lines_q <= lines_sel_s;
                        owner_q <= sel_s;
                        grant_q <= sel_oh_s;
                        ptr_q   <= ptr_d;
                        state_q <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // An empty descriptor completes without touching the engine.
                    if (lines_q == 32'd0) begin
                        done_q  <= owner_oh_s;
                        state_q <= ST_DONE;
                    end else begin
                        start_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A finish wins over a timeout that expires in the same cycle.
                    if (i_dma_finish) begin
                        done_q  <= owner_oh_s;
                        state_q <= ST_DONE;
                    end else if (cnt_max_s) begin
                        timeout_q <= 1'b1;
                        done_q    <= owner_oh_s;
                        cnt_q     <= cnt_d;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_grant      = grant_q;
    assign o_done       = done_q;
    assign o_dma_start  = start_q;
    assign o_dma_mode   = mode_q;
    assign o_src_start  = src_q;
    assign o_dest_start = dest_q;
    assign o_d_lines    = lines_q;
    assign o_owner      = owner_q;
    assign o_timeout    = timeout_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dma_port_arbiter.sv
// Self-checking bench for dma_port_arbiter.
// It runs directed scenarios and then randomized transactions. A
// transaction-level model predicts every outcome: the round-robin winner, the
// latched descriptor, the event cycles and the sticky timeout.
module tb_dma_port_arbiter;

    localparam int NREQ   = 3;
    localparam int TO_W   = 4;
    localparam int TO_CYC = (1 << TO_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                clr;
    logic [NREQ-1:0]     req;
    logic [4*NREQ-1:0]   mode_i;
    logic [32*NREQ-1:0]  src_i;
    logic [32*NREQ-1:0]  dest_i;
    logic [32*NREQ-1:0]  lines_i;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     done;
    logic                dma_start;
    logic [3:0]          dma_mode;
    logic [31:0]         src_start;
    logic [31:0]         dest_start;
    logic [31:0]         d_lines;
    logic                finish;
    logic                busy;
    logic [2:0]          owner;
    logic                timeout;

    logic [3:0]  mode_a  [NREQ];
    logic [31:0] src_a   [NREQ];
    logic [31:0] dest_a  [NREQ];
    logic [31:0] lines_a [NREQ];

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;
    bit to_m     = 1'b0;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign mode_i[4*g +: 4]   = mode_a[g];
        assign src_i[32*g +: 32]  = src_a[g];
        assign dest_i[32*g +: 32] = dest_a[g];
        assign lines_i[32*g +: 32] = lines_a[g];
    end

    always #5 clk = ~clk;

    dma_port_arbiter #(.NREQ(NREQ), .TO_W(TO_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clr        (clr),
        .i_req        (req),
        .i_mode       (mode_i),
        .i_src        (src_i),
        .i_dest       (dest_i),
        .i_lines      (lines_i),
        .o_grant      (grant),
        .o_done       (done),
        .o_dma_start  (dma_start),
        .o_dma_mode   (dma_mode),
        .o_src_start  (src_start),
        .o_dest_start (dest_start),
        .o_d_lines    (d_lines),
        .i_dma_finish (finish),
        .o_busy       (busy),
        .o_owner      (owner),
        .o_timeout    (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 1: nonzero line counts, mode 2: zero allowed (about 1 in 6)
    task automatic rand_desc(input int mode);
        for (int i = 0; i < NREQ; i++) begin
            mode_a[i] = 4'($urandom_range(15, 0));
            src_a[i]  = $urandom;
            dest_a[i] = $urandom;
            if (mode == 2 && $urandom_range(5, 0) == 0) lines_a[i] = 32'd0;
            else lines_a[i] = 32'($urandom_range(4096, 1));
        end
    endtask

    task automatic spurious_idle();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("spur_done", 32'(done), 32'd0);
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_start", 32'(dma_start), 32'd0);
        chk("spur_grant", 32'(grant), 32'd0);
        chk("spur_to", 32'(timeout), 32'(to_m));
    endtask

    // rnd: 0 keep descriptors, 1/2 see rand_desc. d: WAIT cycle of the finish pulse.
    // abort_at > 0: i_clr in that WAIT cycle; < 0: async reset in that WAIT cycle.
    task automatic run_txn(input logic [2:0] rq, input int rnd, input int d, input int abort_at);
        int win;
        int k;
        bit live;
        logic [3:0]  e_mode;
        logic [31:0] e_src;
        logic [31:0] e_dest;
        logic [31:0] e_lines;
        win = -1;
        for (int i = 0; i < NREQ; i++) begin
            k = (ptr_m + i) % NREQ;
            if (win < 0 && ((int'(rq) >> k) & 1) == 1) win = k;
        end
        if (rnd != 0) rand_desc(rnd);
        e_mode  = mode_a[win];
        e_src   = src_a[win];
        e_dest  = dest_a[win];
        e_lines = lines_a[win];
        req = rq;
        tick();
        chk("grant", 32'(grant), 32'(1 << win));
        chk("owner", 32'(owner), 32'(win));
        chk("mode", 32'(dma_mode), 32'(e_mode));
        chk("src", src_start, e_src);
        chk("dest", dest_start, e_dest);
        chk("lines", d_lines, e_lines);
        chk("busy_grant", 32'(busy), 32'd1);
        chk("start_early", 32'(dma_start), 32'd0);
        ptr_m = (win + 1) % NREQ;
        req = '0;
        rand_desc(2);
        tick();
        chk("grant_pulse", 32'(grant), 32'd0);
        chk("src_hold", src_start, e_src);
        chk("lines_hold", d_lines, e_lines);
        if (e_lines == 32'd0) begin
            chk("zl_start", 32'(dma_start), 32'd0);
            chk("zl_done", 32'(done), 32'(1 << win));
            chk("zl_to", 32'(timeout), 32'(to_m));
            tick();
            chk("zl_done_pulse", 32'(done), 32'd0);
            chk("zl_busy", 32'(busy), 32'd0);
        end else begin
            chk("start", 32'(dma_start), 32'd1);
            chk("start_mode", 32'(dma_mode), 32'(e_mode));
            live = 1'b1;
            for (int w = 1; w <= TO_CYC; w++) begin
                if (live) begin
                    if (w == abort_at) begin
                        clr = 1'b1;
                        tick();
                        clr = 1'b0;
                        to_m = 1'b0;
                        chk("clr_busy", 32'(busy), 32'd0);
                        chk("clr_done", 32'(done), 32'd0);
                        chk("clr_start", 32'(dma_start), 32'd0);
                        chk("clr_to", 32'(timeout), 32'd0);
                        chk("clr_owner", 32'(owner), 32'(win));
                        chk("clr_src", src_start, e_src);
                        finish = 1'b1;
                        tick();
                        finish = 1'b0;
                        chk("clr_late_done", 32'(done), 32'd0);
                        chk("clr_late_busy", 32'(busy), 32'd0);
                        live = 1'b0;
                    end else if (-w == abort_at) begin
                        #2;
                        rst_n = 1'b0;
                        #1;
                        ptr_m = 0;
                        to_m  = 1'b0;
                        chk("rst_busy", 32'(busy), 32'd0);
                        chk("rst_owner", 32'(owner), 32'd0);
                        chk("rst_src", src_start, 32'd0);
                        chk("rst_mode", 32'(dma_mode), 32'd0);
                        chk("rst_start", 32'(dma_start), 32'd0);
                        chk("rst_done", 32'(done), 32'd0);
                        @(negedge clk);
                        rst_n = 1'b1;
                        tick();
                        live = 1'b0;
                    end else begin
                        finish = (w == d);
                        tick();
                        finish = 1'b0;
                        if (w == d || w == TO_CYC) begin
                            if (w != d) to_m = 1'b1;
                            chk("done", 32'(done), 32'(1 << win));
                            chk("done_to", 32'(timeout), 32'(to_m));
                            chk("done_busy", 32'(busy), 32'd1);
                            tick();
                            chk("done_pulse", 32'(done), 32'd0);
                            chk("idle_busy", 32'(busy), 32'd0);
                            chk("idle_to", 32'(timeout), 32'(to_m));
                            live = 1'b0;
                        end else begin
                            chk("wait_done", 32'(done), 32'd0);
                            chk("wait_start", 32'(dma_start), 32'd0);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int r;
        int ab;
        rst_n  = 1'b0;
        clr    = 1'b0;
        req    = '0;
        finish = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            mode_a[i] = 4'd0; src_a[i] = 32'd0; dest_a[i] = 32'd0; lines_a[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_start", 32'(dma_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        chk("rst_lines", d_lines, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy0", 32'(busy), 32'd0);

        // round-robin with all requesters active: winners 0,1,2,0
        for (int i = 0; i < 4; i++) run_txn(3'b111, 1, 5, 0);

        // single request with a known descriptor
        mode_a[0] = 4'd2; src_a[0] = 32'h0000_1000; dest_a[0] = 32'h0000_2000; lines_a[0] = 32'd16;
        run_txn(3'b001, 0, 8, 0);

        // zero-length descriptor on requester 2
        mode_a[2] = 4'd5; src_a[2] = 32'h0000_3000; dest_a[2] = 32'h0000_4000; lines_a[2] = 32'd0;
        run_txn(3'b100, 0, 5, 0);

        // finish coincident with the last watchdog cycle
        run_txn(3'b010, 1, TO_CYC, 0);
        spurious_idle();

        // watchdog expiry, then the flag stays set through a normal transfer
        run_txn(3'b001, 1, 99, 0);
        run_txn(3'b010, 1, 3, 0);
        spurious_idle();

        // abort in WAIT, then the pointer successor wins
        run_txn(3'b111, 1, 99, 4);
        run_txn(3'b111, 1, 2, 0);

        for (int n = 0; n < 60; n++) begin
            r  = int'($urandom_range(9, 0));
            ab = (r == 0) ? int'($urandom_range(12, 1)) : 0;
            if (r == 1) spurious_idle();
            run_txn(3'($urandom_range(7, 1)), 2, int'($urandom_range(20, 1)), ab);
        end

        // asynchronous reset mid-transfer
        run_txn(3'b110, 1, 99, -3);
        run_txn(3'b111, 1, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
